zero_strip: RTL and testbench

ZERO_STRIP -- requirements
Module: zero_strip

---
 rtl/wrd_pkg.sv | 15 +
 rtl/zero_strip_stream_reg.sv | 47 ++++
 rtl/zero_strip.sv | 172 +++++++++++++++++
 tb/tb_zero_strip.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrd_pkg.sv
// wrd_pkg: shared definitions for the wrd stream blocks (zero_pad, zero_strip).
// Holds the frame-position state encoding and the default vector geometry.
package wrd_pkg;

    // Default element width (signed) and elements per vector beat
    localparam int WRD_BW         = 8;
    localparam int WRD_VECTOR_LEN = 13;

    // Frame position: FIRST = next accepted beat is the leading pad, BODY = inside a frame
    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } wrd_state_e;

endpackage

// File: rtl/zero_strip_stream_reg.sv
// stream_reg: registered output stage of a valid/ready stream.
// A load captures a new beat; otherwise the beat is held stable while the
// consumer stalls and valid drops on the cycle after it is taken.
// The caller must only load when the stage is empty or being drained.
module stream_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         last_o
);

    logic [W-1:0] data_r;
    logic         valid_r;
    logic         last_r;

    // Output stage: load takes priority, a drain without load empties the stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load_i) begin
            data_r  <= data_i;
            valid_r <= 1'b1;
            last_r  <= last_i;
        end else if (valid_r && ready_i) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign last_o  = last_r;

endmodule

// File: rtl/zero_strip.sv
// zero_strip: removes the first and last beat of every input frame and
// forwards the inner beats unchanged (inverse of 1-leading/1-trailing padding).
// One inner beat is buffered in a hold register so the frame's final beat can
// be recognised before the preceding beat is emitted with last_o.
// Optional feature macro: ZERO_STRIP_PAD_CHECK_EN (flags nonzero discarded pads).
import wrd_pkg::*;

module zero_strip #(
    parameter int BW         = WRD_BW,
    parameter int VECTOR_LEN = WRD_VECTOR_LEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [VECTOR_LEN*BW-1:0]  data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic [VECTOR_LEN*BW-1:0]  data_o,
    output logic                      valid_o,
    output logic                      last_o,
    input  logic                      ready_i,
    output logic                      short_frame_o,
    output logic                      pad_err_o
);

    localparam int DW = VECTOR_LEN * BW;

    wrd_state_e    state_r;
    wrd_state_e    state_nxt_s;
    logic [DW-1:0] hold_r;
    logic          hold_v_r;
    logic          hold_v_nxt_s;
    logic          hold_load_s;
    logic          out_load_s;
    logic          out_last_s;
    logic          out_valid_s;
    logic          ready_s;
    logic          accept_s;
    logic          short_nxt_s;
    logic          short_frame_r;

    // Input acceptance: only a full hold blocks, and then only while the output is stalled
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_FIRST: ready_s = 1'b1;
            ST_BODY: begin
                if (hold_v_r) begin
                    ready_s = !out_valid_s || ready_i;
                end else begin
                    ready_s = 1'b1;
                end
            end
            default: ready_s = 1'b1;
        endcase
    end

    assign accept_s = valid_i & ready_s;

    // Next-state, hold and output-load decisions for each accepted beat
    always_comb begin
        state_nxt_s  = state_r;
        hold_v_nxt_s = hold_v_r;
        hold_load_s  = 1'b0;
        out_load_s   = 1'b0;
        out_last_s   = 1'b0;
        short_nxt_s  = 1'b0;
        case (state_r)
            ST_FIRST: begin
                if (accept_s && last_i) begin
                    // single-beat frame: nothing to forward
                    short_nxt_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s  = ST_BODY;
                    hold_v_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BODY: begin
                if (!hold_v_r) begin
                    if (accept_s && last_i) begin
                        // two-beat frame: trailing pad follows leading pad directly
                        short_nxt_s = 1'b1;
                        state_nxt_s = ST_FIRST;
                    end else if (accept_s) begin
                        hold_load_s  = 1'b1;
                        hold_v_nxt_s = 1'b1;
                    end else begin
                        hold_v_nxt_s = hold_v_r;
                    end
                end else begin
                    if (accept_s && last_i) begin
                        // held beat is the final inner beat; incoming beat is the trailing pad
                        out_load_s   = 1'b1;
                        out_last_s   = 1'b1;
                        hold_v_nxt_s = 1'b0;
                        state_nxt_s  = ST_FIRST;
                    end else if (accept_s) begin
                        out_load_s  = 1'b1;
                        hold_load_s = 1'b1;
                    end else begin
                        hold_v_nxt_s = hold_v_r;
                    end
                end
            end
            default: begin
                state_nxt_s  = ST_FIRST;
                hold_v_nxt_s = 1'b0;
            end
        endcase
    end

    // Frame-position state, hold buffer and short-frame pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_FIRST;
            hold_v_r      <= 1'b0;
            hold_r        <= {DW{1'b0}};
            short_frame_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hold_v_r      <= hold_v_nxt_s;
            short_frame_r <= short_nxt_s;
            if (hold_load_s) begin
                hold_r <= data_i;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    stream_reg #(
        .W (DW)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (out_load_s),
        .data_i  (hold_r),
        .last_i  (out_last_s),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (out_valid_s),
        .last_o  (last_o)
    );

`ifdef ZERO_STRIP_PAD_CHECK_EN
    logic pad_discard_s;
    logic pad_err_r;

    // Every discarded beat is either a frame's first beat or its last beat
    assign pad_discard_s = accept_s && ((state_r == ST_FIRST) || last_i);

    // Flag a discarded pad that carried nonzero data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pad_err_r <= 1'b0;
        end else begin
            pad_err_r <= pad_discard_s && (|data_i);
        end
    end

    assign pad_err_o = pad_err_r;
`else
    assign pad_err_o = 1'b0;
`endif

    assign ready_o       = ready_s;
    assign valid_o       = out_valid_s;
    assign short_frame_o = short_frame_r;

endmodule

// File: tb/tb_zero_strip.sv
// tb_zero_strip: directed frames with a queue-based scoreboard; a negedge
// monitor pops and compares every output transfer.
module tb_zero_strip;

    localparam int BW = 8;
    localparam int VL = 13;
    localparam int DW = BW * VL;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          short_frame_o;
    logic          pad_err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sf_cnt   = 0;
    int pe_cnt   = 0;
    int wait_sum = 0;
    logic [DW:0] exp_q[$];
    int          out_cyc[$];

    always #5 clk_i = ~clk_i;

    zero_strip #(.BW(BW), .VECTOR_LEN(VL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .last_i        (last_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .ready_i       (ready_i),
        .short_frame_o (short_frame_o),
        .pad_err_o     (pad_err_o)
    );

    function automatic logic [DW-1:0] beat(input logic [BW-1:0] v);
        logic [DW-1:0] b;
        for (int i = 0; i < VL; i++) b[i*BW +: BW] = v;
        return b;
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: count pulses and score every output transfer
    always @(negedge clk_i) begin
        if (short_frame_o) sf_cnt++;
        if (pad_err_o) pe_cnt++;
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %h required no output", {last_o, data_o});
            end else begin
                check("out_beat", {last_o, data_o}, exp_q.pop_front());
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic push_exp(input logic [BW-1:0] v, input logic last);
        exp_q.push_back({last, beat(v)});
    endtask

    task automatic send_beat(input logic [BW-1:0] v, input logic last);
        int waits;
        waits   = 0;
        data_i  = beat(v);
        last_i  = last;
        valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_o && waits < 100) begin
            waits++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready_o=0 required ready_o=1 within 100 cycles");
        end
        wait_sum += waits;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check(name, exp_q.size(), 0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic check_consec(input string name, input int a, input int b);
        if (out_cyc.size() > b) check(name, out_cyc[b] - out_cyc[a], 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int sf0;
        int pe0;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_last_o", last_o, 1'b0);
        check("rst_data_o", data_o, '0);
        check("rst_short", short_frame_o, 1'b0);
        check("rst_pad_err", pad_err_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        // Basic frame 0,1,2,3,0 with free-flowing output
        sf0 = sf_cnt;
        out_cyc.delete();
        push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b0); push_exp(8'd3, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd1, 1'b0); send_beat(8'd2, 1'b0);
        send_beat(8'd3, 1'b0); send_beat(8'd0, 1'b1);
        drain("t1_drain");
        check("t1_out_count", out_cyc.size(), 3);
        check_consec("t1_consec_a", 0, 1);
        check_consec("t1_consec_b", 1, 2);
        check("t1_short", sf_cnt - sf0, 0);

        // Same frame with a 4-cycle downstream stall after the first output
        out_cyc.delete();
        ready_i = 1'b0;
        push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b0); push_exp(8'd3, 1'b1);
        fork
            begin
                send_beat(8'd0, 1'b0); send_beat(8'd1, 1'b0); send_beat(8'd2, 1'b0);
                send_beat(8'd3, 1'b0); send_beat(8'd0, 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge clk_i);
                while (!valid_o && n < 50) begin
                    n++;
                    @(negedge clk_i);
                end
                check("t2_valid_seen", valid_o, 1'b1);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk_i);
                    check("t2_stall_data", {last_o, data_o}, {1'b0, beat(8'd1)});
                    check("t2_stall_ready", ready_o, 1'b0);
                end
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain("t2_drain");
        check("t2_out_count", out_cyc.size(), 3);

        // Two-beat frame (discarded, short pulse) then 0,7,0
        sf0 = sf_cnt;
        out_cyc.delete();
        push_exp(8'd7, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd0, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd7, 1'b0); send_beat(8'd0, 1'b1);
        drain("t3_drain");
        check("t3_short", sf_cnt - sf0, 1);
        check("t3_out_count", out_cyc.size(), 1);

        // Back-to-back frames with no idle gap
        out_cyc.delete();
        wait_sum = 0;
        push_exp(8'd5, 1'b0); push_exp(8'd6, 1'b1); push_exp(8'd8, 1'b0); push_exp(8'd9, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd5, 1'b0); send_beat(8'd6, 1'b0); send_beat(8'd0, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd8, 1'b0); send_beat(8'd9, 1'b0); send_beat(8'd0, 1'b1);
        check("t4_no_stall", wait_sum, 0);
        drain("t4_drain");
        check("t4_out_count", out_cyc.size(), 4);
        check_consec("t4_consec_a", 0, 1);
        check_consec("t4_consec_b", 2, 3);

        // Reset abandons a frame in flight
        out_cyc.delete();
        send_beat(8'd0, 1'b0); send_beat(8'd4, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t5_rst_valid", valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        push_exp(8'd1, 1'b1);
        send_beat(8'd0, 1'b0); send_beat(8'd1, 1'b0); send_beat(8'd0, 1'b1);
        drain("t5_drain");
        check("t5_out_count", out_cyc.size(), 1);

        // Nonzero pads 3,1,2,9
        pe0 = pe_cnt;
        out_cyc.delete();
        push_exp(8'd1, 1'b0); push_exp(8'd2, 1'b1);
        send_beat(8'd3, 1'b0); send_beat(8'd1, 1'b0); send_beat(8'd2, 1'b0); send_beat(8'd9, 1'b1);
        drain("t6_drain");
        check("t6_out_count", out_cyc.size(), 2);
`ifdef ZERO_STRIP_PAD_CHECK_EN
        check("t6_pad_err", pe_cnt - pe0, 2);
        check("total_pad_err", pe_cnt, 2);
`else
        check("t6_pad_err", pe_cnt - pe0, 0);
        check("total_pad_err", pe_cnt, 0);
`endif
        check("total_short", sf_cnt, 1);

        repeat (3) @(posedge clk_i);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
